i2c_rd_collector: RTL and testbench

- Sits directly downstream of the I2C wrapper. It consumes the wrapper's dataout/DataValid read-return pulses.
- Tags each returned byte with the address of the read that produced it, then buffers the pairs in a FIFO drained by a valid/ready consumer.
- Snoops the read requests issued to the wrapper and issues credit-based flow control (rd_ok) back to the requester, so the buffer can never overflow.

---
 rtl/i2c_rd_collector_if.sv | 46 ++++
 rtl/i2c_rd_collector.sv | 143 ++++++++++++++
 tb/tb_i2c_rd_collector.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_rd_collector_if.sv
// ---------------------------------------------------------------------------
// i2c_rd_collector_if
// Bundles the read-snoop, read-return, output-stream and status signals of
// the I2C read-return collector.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface i2c_rd_collector_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 6,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 rd_req;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic                 rd_ok;
    logic                 DataValid;
    logic [DATAWIDTH-1:0] dataout;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic [ADDRWIDTH-1:0] out_addr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        outstanding;
    logic                 err_orphan;
    logic                 err_overrun;
    logic                 clr_err;

    // Requester / wrapper / consumer side
    modport master (
        output rd_req, rd_addr, DataValid, dataout, out_ready, clr_err,
        input  rd_ok, out_valid, out_data, out_addr, count, outstanding,
               err_orphan, err_overrun
    );

    // Collector side
    modport slave (
        input  rd_req, rd_addr, DataValid, dataout, out_ready, clr_err,
        output rd_ok, out_valid, out_data, out_addr, count, outstanding,
               err_orphan, err_overrun
    );
endinterface

`default_nettype wire

// File: rtl/i2c_rd_collector.sv
// ---------------------------------------------------------------------------
// i2c_rd_collector
// Tags I2C read-return bytes with their request address, buffers the pairs in
// a FWFT FIFO and issues credit-based flow control to the read requester.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_rd_collector #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 6,
    parameter int DEPTH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    i2c_rd_collector_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Tag queue: addresses of reads in flight
    logic [ADDRWIDTH-1:0] tag_mem_q [DEPTH];
    logic [PW-1:0]        tag_wp_q, tag_wp_d;
    logic [PW-1:0]        tag_rp_q, tag_rp_d;
    logic [CW-1:0]        outst_q, outst_d;

    // Data FIFO: {tag, data} pairs awaiting the consumer
    logic [DATAWIDTH-1:0] dat_mem_q [DEPTH];
    logic [ADDRWIDTH-1:0] adr_mem_q [DEPTH];
    logic [PW-1:0]        d_wp_q, d_wp_d;
    logic [PW-1:0]        d_rp_q, d_rp_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [DATAWIDTH-1:0] last_data_q, last_data_d;
    logic [ADDRWIDTH-1:0] last_addr_q, last_addr_d;
    logic                 err_orphan_q, err_orphan_d;
    logic                 err_overrun_q, err_overrun_d;

    logic [CW:0]          occupancy;
    logic                 rd_ok;
    logic                 tag_push;
    logic                 overrun_ev;
    logic                 tag_avail;
    logic                 capture;
    logic                 orphan_ev;
    logic                 head_valid;
    logic                 pop;

    // Credit uses registered state only; a pop this cycle frees credit next cycle
    assign occupancy  = {1'b0, outst_q} + {1'b0, cnt_q};
    assign rd_ok      = (occupancy < DEPTH_C);
    assign tag_push   = bus.rd_req & rd_ok;
    assign overrun_ev = bus.rd_req & ~rd_ok;

    // A tag pushed this cycle is not yet eligible to match a return
    assign tag_avail  = (outst_q != '0);
    assign capture    = bus.DataValid & tag_avail;
    assign orphan_ev  = bus.DataValid & ~tag_avail;

    assign head_valid = (cnt_q != '0);
    assign pop        = head_valid & bus.out_ready;

    always_comb begin
        tag_wp_d = tag_push ? tag_wp_q + PTR_ONE : tag_wp_q;
        tag_rp_d = capture  ? tag_rp_q + PTR_ONE : tag_rp_q;
        d_wp_d   = capture  ? d_wp_q + PTR_ONE   : d_wp_q;
        d_rp_d   = pop      ? d_rp_q + PTR_ONE   : d_rp_q;

        outst_d = outst_q;
        case ({tag_push, capture})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase

        cnt_d = cnt_q;
        case ({capture, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // Remember the entry leaving so the outputs hold it once the FIFO empties
        last_data_d = pop ? dat_mem_q[d_rp_q] : last_data_q;
        last_addr_d = pop ? adr_mem_q[d_rp_q] : last_addr_q;

        // A new error event takes priority over a simultaneous clear
        err_orphan_d  = orphan_ev  ? 1'b1 : (bus.clr_err ? 1'b0 : err_orphan_q);
        err_overrun_d = overrun_ev ? 1'b1 : (bus.clr_err ? 1'b0 : err_overrun_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_wp_q      <= '0;
            tag_rp_q      <= '0;
            outst_q       <= '0;
            d_wp_q        <= '0;
            d_rp_q        <= '0;
            cnt_q         <= '0;
            last_data_q   <= '0;
            last_addr_q   <= '0;
            err_orphan_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            tag_wp_q      <= tag_wp_d;
            tag_rp_q      <= tag_rp_d;
            outst_q       <= outst_d;
            d_wp_q        <= d_wp_d;
            d_rp_q        <= d_rp_d;
            cnt_q         <= cnt_d;
            last_data_q   <= last_data_d;
            last_addr_q   <= last_addr_d;
            err_orphan_q  <= err_orphan_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters qualify every read
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wp_q] <= bus.rd_addr;
        end
        if (capture) begin
            dat_mem_q[d_wp_q] <= bus.dataout;
            adr_mem_q[d_wp_q] <= tag_mem_q[tag_rp_q];
        end
    end

    assign bus.rd_ok       = rd_ok;
    assign bus.out_valid   = head_valid;
    assign bus.out_data    = head_valid ? dat_mem_q[d_rp_q] : last_data_q;
    assign bus.out_addr    = head_valid ? adr_mem_q[d_rp_q] : last_addr_q;
    assign bus.count       = cnt_q;
    assign bus.outstanding = outst_q;
    assign bus.err_orphan  = err_orphan_q;
    assign bus.err_overrun = err_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_rd_collector.sv
// ---------------------------------------------------------------------------
// tb_i2c_rd_collector
// Directed and randomized scoreboard bench for the I2C read-return collector.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_rd_collector;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_rd_collector_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .DEPTH(D)) bus ();

    i2c_rd_collector #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of in-flight tags, expected output stream, flags
    logic [AW-1:0]    tagq [$];
    logic [AW+DW-1:0] sb   [$];
    int               m_cnt;
    bit               m_orph;
    bit               m_ovr;
    logic [AW+DW-1:0] m_last;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit model_ok();
        return (tagq.size() + m_cnt) < D;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ":count"},       bus.count,       m_cnt);
        chk({tag, ":outstanding"}, bus.outstanding, tagq.size());
        chk({tag, ":rd_ok"},       bus.rd_ok,       model_ok());
        chk({tag, ":out_valid"},   bus.out_valid,   m_cnt > 0);
        chk({tag, ":err_orphan"},  bus.err_orphan,  m_orph);
        chk({tag, ":err_overrun"}, bus.err_overrun, m_ovr);
    endtask

    // One clock of stimulus; model advanced from the rules, then status checked after the edge
    task automatic cycle(input bit rq, input logic [AW-1:0] a, input bit dv,
                         input logic [DW-1:0] d, input bit rdy, input bit clr);
        bit ok, cap, orph, pop;
        bus.rd_req    = rq;
        bus.rd_addr   = a;
        bus.DataValid = dv;
        bus.dataout   = d;
        bus.out_ready = rdy;
        bus.clr_err   = clr;
        ok   = model_ok();
        cap  = dv && (tagq.size() > 0);
        orph = dv && !cap;
        pop  = (m_cnt > 0) && rdy;
        if (cap) begin
            sb.push_back({tagq[0], d});
            void'(tagq.pop_front());
            m_cnt++;
        end
        if (pop) m_cnt--;
        if (rq && ok) tagq.push_back(a);
        m_orph = orph ? 1'b1 : (clr ? 1'b0 : m_orph);
        m_ovr  = (rq && !ok) ? 1'b1 : (clr ? 1'b0 : m_ovr);
        @(posedge clk);
        #1;
        check_status("step");
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    // Monitor: compares the presented head against the scoreboard on every accept
    always @(negedge clk) begin
        if (reset) begin
            m_last = '0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("head_addr", bus.out_addr, sb[0][AW+DW-1:DW]);
                chk("head_data", bus.out_data, sb[0][DW-1:0]);
                if (bus.out_ready) m_last = sb.pop_front();
            end
        end else begin
            chk("hold_addr", bus.out_addr, m_last[AW+DW-1:DW]);
            chk("hold_data", bus.out_data, m_last[DW-1:0]);
        end
    end

    task automatic clear_model();
        tagq.delete();
        sb.delete();
        m_cnt  = 0;
        m_orph = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic zero_inputs();
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.DataValid = 1'b0;
        bus.dataout = '0; bus.out_ready = 1'b0; bus.clr_err = 1'b0;
    endtask

    initial begin
        clear_model();
        m_last = '0;
        zero_inputs();
        reset = 1'b1;
        #1;
        check_status("reset");
        chk("reset:out_data", bus.out_data, 0);
        chk("reset:out_addr", bus.out_addr, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single read, return three cycles later, then drain
        cycle(1'b1, 6'h05, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        cycle(1'b0, '0, 1'b1, 8'hA5, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Credit exhaustion then an overrun attempt
        for (int i = 1; i <= 4; i++) cycle(1'b1, AW'(i), 1'b0, '0, 1'b0, 1'b0);
        chk("credit:rd_ok", bus.rd_ok, 0);
        cycle(1'b1, 6'h3E, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // In-order tagging with backpressure, then drain one per cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(6'h10 + i), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
        chk("bp:count", bus.count, 4);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Orphans and clear priority
        cycle(1'b0, '0, 1'b1, 8'h99, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 8'h98, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Same-cycle request on empty queue with return is an orphan; tag still pushed
        cycle(1'b1, 6'h2A, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h12, 1'b0, 1'b1);
        cycle(1'b1, 6'h15, 1'b0, '0, 1'b0, 1'b0);
        // outstanding=1, count=1: request, return and pop together
        cycle(1'b1, 6'h3F, 1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h55, 1'b1, 1'b0);
        idle(1'b1);

        // Async reset with count=3, outstanding=1
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(6'h30 + i), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        zero_inputs();
        reset = 1'b1;
        #1;
        clear_model();
        check_status("async_reset");
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic, occasionally violating credit or returning unrequested data
        for (int n = 0; n < 600; n++) begin
            bit rq, dv;
            rq = model_ok() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            dv = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            cycle(rq, AW'($urandom), dv, DW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // Return everything in flight and drain, bounded
        for (int n = 0; n < 4 * D && (tagq.size() > 0 || m_cnt > 0); n++)
            cycle(1'b0, '0, tagq.size() > 0, DW'($urandom), 1'b1, 1'b0);
        chk("final:sb_empty", sb.size(), 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
